// File: rtl/pcs_slip_sched.sv
// pcs_slip_sched: shares one SERDES gearbox bitslip control between lane block-lock FSMs.
// Grants one eligible lane at a time (round-robin), pulses bitslip, waits for the gearbox
// to settle, then pulses slip_done back to that lane. Also reports all-lanes-locked and
// keeps per-lane saturating slip counters for debug.
module pcs_slip_sched #(
  parameter int unsigned LANE_N     = 4,
  parameter int unsigned HOLD_CYC   = 16,
  parameter int unsigned SLIP_CNT_W = 8
) (
  input  logic                         clk,
  input  logic                         nreset,
  input  logic [LANE_N-1:0]            signal_ok_i,
  input  logic [LANE_N-1:0]            slip_req_i,
  input  logic [LANE_N-1:0]            lock_i,
  output logic [LANE_N-1:0]            slip_lane_o,
  output logic [LANE_N-1:0]            slip_done_o,
  output logic                         busy_o,
  output logic                         all_lock_o,
  output logic [LANE_N*SLIP_CNT_W-1:0] slip_cnt_o
);

  localparam int unsigned PTR_W  = (LANE_N > 1) ? $clog2(LANE_N) : 1;
  localparam int unsigned HOLD_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [HOLD_W-1:0]     HOLD_LOAD = HOLD_W'(HOLD_CYC - 1);
  localparam logic [SLIP_CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic [3:0] {
    StIdle = 4'b0001,
    StSlip = 4'b0010,
    StWait = 4'b0100,
    StDone = 4'b1000
  } state_e;

  state_e                               r_state;
  logic [PTR_W-1:0]                     r_rr_ptr;
  logic [PTR_W-1:0]                     r_grant;
  logic [HOLD_W-1:0]                    r_hold;
  logic [LANE_N-1:0]                    r_slip_lane;
  logic [LANE_N-1:0]                    r_slip_done;
  logic                                 r_busy;
  logic                                 r_all_lock;
  logic [LANE_N-1:0][SLIP_CNT_W-1:0]    r_slip_cnt;

  logic [LANE_N-1:0]                    w_eligible;
  logic [LANE_N-1:0]                    w_grant_oh;
  logic [LANE_N-1:0]                    w_cur_oh;
  logic [PTR_W-1:0]                     w_grant;
  logic [PTR_W-1:0]                     w_rr_next;
  logic                                 w_found;
  logic                                 w_start;
  logic                                 w_abort;
  int unsigned                          w_idx;

  assign w_eligible = slip_req_i & signal_ok_i;

  // Round-robin search: first eligible lane at or after r_rr_ptr, wrapping.
  always_comb begin
    w_grant = '0;
    w_found = 1'b0;
    w_idx   = 0;
    for (int unsigned k = 0; k < LANE_N; k++) begin
      w_idx = 32'(r_rr_ptr) + k;
      if (w_idx >= LANE_N) begin
        w_idx = w_idx - LANE_N;
      end
      if (!w_found && w_eligible[w_idx[PTR_W-1:0]]) begin
        w_found = 1'b1;
        w_grant = PTR_W'(w_idx);
      end
    end
  end

  // One-hot decode of the candidate grant and of the registered grant.
  always_comb begin
    w_grant_oh = '0;
    w_cur_oh   = '0;
    for (int i = 0; i < LANE_N; i++) begin
      w_grant_oh[i] = (w_grant == PTR_W'(i));
      w_cur_oh[i]   = (r_grant == PTR_W'(i));
    end
  end

  // Pointer advance wraps at the last lane; for a single lane it stays at 0.
  assign w_rr_next = (w_grant == PTR_W'(LANE_N - 1)) ? '0 : w_grant + PTR_W'(1);
  assign w_start   = (r_state == StIdle) && w_found;
  // Granted lane lost signal: abandon the sequence without a done pulse.
  assign w_abort   = ~|(signal_ok_i & w_cur_oh);

  // Sequencer FSM with registered pulse and busy outputs.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state     <= StIdle;
      r_rr_ptr    <= '0;
      r_grant     <= '0;
      r_hold      <= '0;
      r_slip_lane <= '0;
      r_slip_done <= '0;
      r_busy      <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_found) begin
            r_grant     <= w_grant;
            r_rr_ptr    <= w_rr_next;
            r_slip_lane <= w_grant_oh;
            r_busy      <= 1'b1;
            r_state     <= StSlip;
          end
        end
        StSlip: begin
          r_slip_lane <= '0;
          if (w_abort) begin
            r_busy  <= 1'b0;
            r_state <= StIdle;
          end else begin
            r_hold  <= HOLD_LOAD;
            r_state <= StWait;
          end
        end
        StWait: begin
          if (w_abort) begin
            r_hold  <= '0;
            r_busy  <= 1'b0;
            r_state <= StIdle;
          end else if (r_hold == '0) begin
            r_slip_done <= w_cur_oh;
            r_state     <= StDone;
          end else begin
            r_hold <= r_hold - HOLD_W'(1);
          end
        end
        StDone: begin
          r_slip_done <= '0;
          r_busy      <= 1'b0;
          r_state     <= StIdle;
        end
        default: begin
          r_slip_lane <= '0;
          r_slip_done <= '0;
          r_busy      <= 1'b0;
          r_state     <= StIdle;
        end
      endcase
    end
  end

  // Saturating per-lane slip counters, bumped as the slip pulse is issued.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_slip_cnt <= '0;
    end else if (w_start) begin
      for (int i = 0; i < LANE_N; i++) begin
        if (w_grant_oh[i] && (r_slip_cnt[i] != CNT_MAX)) begin
          r_slip_cnt[i] <= r_slip_cnt[i] + SLIP_CNT_W'(1);
        end
      end
    end
  end

  // All-lanes-locked status, independent of the sequencer.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_all_lock <= 1'b0;
    end else begin
      r_all_lock <= &(lock_i & signal_ok_i);
    end
  end

  assign slip_lane_o = r_slip_lane;
  assign slip_done_o = r_slip_done;
  assign busy_o      = r_busy;
  assign all_lock_o  = r_all_lock;
  assign slip_cnt_o  = r_slip_cnt;

endmodule
